// File: rtl/alu_sequencer.sv
// alu_sequencer: steps an external 8-bit ALU datapath through ADD, SHIFT,
// COUNT and LOGIC commands and returns the captured result on a valid/ready
// response channel. Strobes and the response are registered. cmd_ready and
// busy are decoded directly from the state.
module alu_sequencer #(
    parameter int LEN_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [DATA_W-1:0] i_cmd_a,
    input  logic [DATA_W-1:0] i_cmd_b,
    input  logic              i_cmd_cin,
    input  logic [LEN_W-1:0]  i_cmd_len,
    output logic [DATA_W-1:0] o_alu_x,
    output logic [DATA_W-1:0] o_alu_y,
    output logic              o_alu_L,
    output logic              o_alu_En,
    output logic [1:0]        o_alu_s,
    input  logic [DATA_W-1:0] i_alu_f,
    input  logic              i_alu_cout,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_cout,
    output logic              o_busy
);

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SHIFT = 2'b01;
    localparam logic [1:0] OP_COUNT = 2'b10;
    localparam logic [1:0] OP_LOGIC = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_SAMPLE = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_alu_x;
    logic [DATA_W-1:0] r_alu_y;
    logic [1:0]        r_alu_s;
    logic              r_cin;
    logic              r_alu_L;
    logic              r_alu_En;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_cout;
    logic [LEN_W-1:0]  r_cnt;

    logic              w_accept;
    logic [1:0]        w_op;
    logic              w_cin;
    logic              w_run_last;
    logic              w_capture;
    logic              w_alu_L_nxt;
    logic              w_alu_En_nxt;
    logic              w_rsp_valid_nxt;

    // A zero run length still runs for one cycle.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

    // ADD and LOGIC finish after a single RUN cycle with no SAMPLE phase.
    function automatic logic is_single(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_LOGIC);
    endfunction

    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign w_accept    = i_cmd_valid && (r_state == S_IDLE);

    // In IDLE the incoming command decides the next strobes. Later the latched copy decides them.
    assign w_op        = (r_state == S_IDLE) ? i_cmd_op  : r_alu_s;
    assign w_cin       = (r_state == S_IDLE) ? i_cmd_cin : r_cin;
    assign w_run_last  = (r_cnt <= LEN_W'(1));
    assign w_capture   = ((r_state == S_RUN) && w_run_last && is_single(r_alu_s)) ||
                         (r_state == S_SAMPLE);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = (i_cmd_op == OP_COUNT) ? S_LOAD : S_RUN;
            S_LOAD:   w_state_nxt = S_RUN;
            S_RUN:    if (w_run_last) w_state_nxt = is_single(r_alu_s) ? S_RESP : S_SAMPLE;
            S_SAMPLE: w_state_nxt = S_RESP;
            S_RESP:   if (i_rsp_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: the value each registered strobe takes in the coming state
    always_comb begin
        w_alu_L_nxt     = 1'b0;
        w_alu_En_nxt    = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        case (w_state_nxt)
            S_LOAD: begin
                w_alu_L_nxt  = 1'b1;
                w_alu_En_nxt = 1'b1;
            end
            S_RUN: begin
                w_alu_L_nxt  = (w_op == OP_ADD) && w_cin;
                w_alu_En_nxt = (w_op == OP_COUNT);
            end
            S_RESP:  w_rsp_valid_nxt = 1'b1;
            default: ;
        endcase
    end

    // Registered datapath strobes and response valid
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alu_L     <= 1'b0;
            r_alu_En    <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_alu_L     <= w_alu_L_nxt;
            r_alu_En    <= w_alu_En_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
        end
    end

    // Command latch. Operands and op select stay fixed for the whole command.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alu_x <= '0;
            r_alu_y <= '0;
            r_alu_s <= 2'b00;
            r_cin   <= 1'b0;
        end else if (w_accept) begin
            r_alu_x <= i_cmd_a;
            r_alu_y <= i_cmd_b;
            r_alu_s <= i_cmd_op;
            r_cin   <= i_cmd_cin;
        end
    end

    // RUN length down-counter. It leaves RUN at 1 and then parks at 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= is_single(i_cmd_op) ? LEN_W'(1) : eff_len(i_cmd_len);
        end else if ((r_state == S_RUN) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - LEN_W'(1);
        end
    end

    // Result capture. The value is held stable through RESP and afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_data <= '0;
            r_rsp_cout <= 1'b0;
        end else if (w_capture) begin
            r_rsp_data <= i_alu_f;
            r_rsp_cout <= (r_alu_s == OP_ADD) && i_alu_cout;
        end
    end

    assign o_alu_x     = r_alu_x;
    assign o_alu_y     = r_alu_y;
    assign o_alu_s     = r_alu_s;
    assign o_alu_L     = r_alu_L;
    assign o_alu_En    = r_alu_En;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_cout  = r_rsp_cout;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer. It includes a behavioural ALU datapath: an
// adder, a shift register fed from x[0], a loadable up-counter, and AND.
// A transaction-level model checks the DUT every cycle.
// Directed commands check fixed, hand-computed results.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_cin;
    logic [1:0] cmd_op;
    logic [7:0] cmd_a, cmd_b;
    logic [3:0] cmd_len;
    logic [7:0] alu_x, alu_y, alu_f;
    logic       alu_L, alu_En, alu_cout;
    logic [1:0] alu_s;
    logic       rsp_valid, rsp_ready, rsp_cout, busy;
    logic [7:0] rsp_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.LEN_W(4), .DATA_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
        .i_cmd_cin(cmd_cin), .i_cmd_len(cmd_len),
        .o_alu_x(alu_x), .o_alu_y(alu_y), .o_alu_L(alu_L), .o_alu_En(alu_En),
        .o_alu_s(alu_s), .i_alu_f(alu_f), .i_alu_cout(alu_cout),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_cout(rsp_cout), .o_busy(busy)
    );

    // ---------------- behavioural ALU datapath ----------------
    logic [7:0] alu_cnt = 8'h00;
    logic [7:0] alu_sh  = 8'h00;
    logic [8:0] sum;
    assign sum = {1'b0, alu_x} + {1'b0, alu_y} + {8'd0, alu_L};

    always @(posedge clk) begin
        if (alu_En) alu_cnt <= alu_L ? alu_x : alu_cnt + 8'd1;
        if (alu_s == 2'b01) alu_sh <= {alu_sh[6:0], alu_x[0]};
        else                alu_sh <= 8'h00;
    end

    always_comb begin
        alu_f = 8'h00;
        case (alu_s)
            2'b00:   alu_f = sum[7:0];
            2'b01:   alu_f = alu_sh;
            2'b10:   alu_f = alu_cnt;
            default: alu_f = alu_x & alu_y;
        endcase
    end
    // Carry-out is forced high outside ADD, so a leaked cout shows up.
    assign alu_cout = (alu_s == 2'b00) ? sum[8] : 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected {cout, data}. SHIFT assumes the shift register starts clear.
    function automatic logic [8:0] model_result(input logic [1:0] op, input logic [7:0] a,
                                                input logic [7:0] b, input logic cin, input int n);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b} + 9'(cin);
            2'b01:   return a[0] ? ((n >= 8) ? 9'h0FF : 9'((1 << n) - 1)) : 9'h000;
            2'b10:   return {1'b0, a + 8'(n)};
            default: return {1'b0, a & b};
        endcase
    endfunction

    // ---------------- transaction-level model and per-cycle compare ----------------
    initial begin : model
        bit         m_busy, m_go, m_done;
        int         m_j, m_n, m_lat;
        logic [1:0] m_op, p_op;
        logic [7:0] m_a, m_b, p_a, p_b;
        logic       m_cin, p_cin, e_L, e_En;
        logic [3:0] p_len;
        logic [8:0] m_res;
        m_busy = 0; m_go = 0; m_done = 0; m_j = 0; m_n = 1; m_lat = 1;
        m_op = 0; m_a = 0; m_b = 0; m_cin = 0; m_res = 0;
        p_op = 0; p_a = 0; p_b = 0; p_cin = 0; p_len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_go = 0; m_done = 0;
                chk("m_rst_ctrl", 32'({busy, cmd_ready, rsp_valid, alu_L, alu_En, rsp_cout}), 32'b010000);
                chk("m_rst_data", 32'({alu_s, alu_x, alu_y, rsp_data}), 32'd0);
            end else begin
                if (m_go) begin
                    m_busy = 1; m_j = 0;
                    m_op = p_op; m_a = p_a; m_b = p_b; m_cin = p_cin;
                    m_n = (p_len == 4'd0) ? 1 : int'(p_len);
                    m_lat = (m_op == 2'b10) ? m_n + 2 : (m_op == 2'b01) ? m_n + 1 : 1;
                    m_res = model_result(m_op, m_a, m_b, m_cin, m_n);
                end else if (m_done) begin
                    m_busy = 0;
                end else if (m_busy) begin
                    m_j++;
                end
                m_go = 0; m_done = 0;
                chk("m_busy_ready", 32'({busy, cmd_ready}), 32'({m_busy, ~m_busy}));
                if (m_busy) begin
                    chk("m_operand_hold", 32'({alu_s, alu_x, alu_y}), 32'({m_op, m_a, m_b}));
                    if (m_j < m_lat) begin
                        e_L  = (m_j == 0) && ((m_op == 2'b10) || ((m_op == 2'b00) && m_cin));
                        e_En = (m_op == 2'b10) && (m_j <= m_n);
                        chk("m_run_strobes", 32'({rsp_valid, alu_L, alu_En}), 32'({1'b0, e_L, e_En}));
                    end else begin
                        chk("m_resp", 32'({rsp_valid, alu_L, alu_En, rsp_cout, rsp_data}),
                            32'({3'b100, m_res}));
                    end
                end else begin
                    chk("m_idle_strobes", 32'({rsp_valid, alu_L, alu_En}), 32'd0);
                end
                if (!m_busy && cmd_valid) begin
                    m_go = 1; p_op = cmd_op; p_a = cmd_a; p_b = cmd_b; p_cin = cmd_cin; p_len = cmd_len;
                end
                if (m_busy && (m_j >= m_lat) && rsp_ready) m_done = 1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [3:0] len);
        bit acc;
        int t;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_len = len;
        acc = 0; t = 0;
        while (!acc && t < 60) begin
            @(negedge clk); acc = cmd_ready;
            @(posedge clk); #1; t++;
        end
        cmd_valid = 1'b0;
        chk("cmd_accepted", 32'(acc), 32'd1);
    endtask

    task automatic do_cmd(input string nm, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic cin, input logic [3:0] len,
                          input int e_lat, input logic [7:0] e_data, input logic e_cout,
                          input int e_nl, input int e_ne);
        int lat, nl, ne, ns;
        rsp_ready = 1'b1;
        send(op, a, b, cin, len);
        lat = 0; nl = 0; ne = 0; ns = 0;
        while (!rsp_valid && lat < 40) begin
            nl += int'(alu_L); ne += int'(alu_En); ns += int'(alu_s == op);
            @(posedge clk); #1; lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(e_lat));
        chk({nm, "_data"}, 32'(rsp_data), 32'(e_data));
        chk({nm, "_cout"}, 32'(rsp_cout), 32'(e_cout));
        chk({nm, "_L_cycles"}, 32'(nl), 32'(e_nl));
        chk({nm, "_En_cycles"}, 32'(ne), 32'(e_ne));
        chk({nm, "_s_cycles"}, 32'(ns), 32'(e_lat));
        @(posedge clk); #1;
        chk({nm, "_valid_pulse_end"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin : stim
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = 8'h00; cmd_b = 8'h00;
        cmd_cin = 1'b0; cmd_len = 4'd0; rsp_ready = 1'b1;
        #2;
        chk("reset_ctrl", 32'({busy, cmd_ready, rsp_valid, alu_L, alu_En, rsp_cout}), 32'b010000);
        chk("reset_data", 32'({alu_s, alu_x, alu_y, rsp_data}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        //     name        op     a      b      cin  len    lat data   cout nL nE
        do_cmd("add_f0_20", 2'b00, 8'hF0, 8'h20, 1'b1, 4'd5,  1, 8'h11, 1'b1, 1, 0);
        do_cmd("count_fe3", 2'b10, 8'hFE, 8'h00, 1'b0, 4'd3,  5, 8'h01, 1'b0, 1, 4);
        do_cmd("shift_len0", 2'b01, 8'h01, 8'h00, 1'b0, 4'd0, 2, 8'h01, 1'b0, 0, 0);
        do_cmd("add_ff_01", 2'b00, 8'hFF, 8'h01, 1'b0, 4'd0,  1, 8'h00, 1'b1, 0, 0);
        do_cmd("shift_len3", 2'b01, 8'h03, 8'h00, 1'b0, 4'd3, 4, 8'h07, 1'b0, 0, 0);
        do_cmd("count_max", 2'b10, 8'hF5, 8'h00, 1'b0, 4'd15, 17, 8'h04, 1'b0, 1, 16);
        do_cmd("shift_len10", 2'b01, 8'h81, 8'h00, 1'b0, 4'd10, 11, 8'hFF, 1'b0, 0, 0);

        // LOGIC with the response stalled for 5 cycles and a second command waiting
        rsp_ready = 1'b0;
        send(2'b11, 8'h3C, 8'h0F, 1'b1, 4'd0);
        @(posedge clk); #1;
        chk("logic_latency", 32'(rsp_valid), 32'd1);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'h05; cmd_b = 8'h06; cmd_cin = 1'b0; cmd_len = 4'd0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", 32'({rsp_cout, rsp_data}), 32'h00C);
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            if (i < 4) begin @(posedge clk); #1; end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("handshake_valid_drop", 32'(rsp_valid), 32'd0);
        chk("handshake_idle_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        chk("pending_accepted", 32'(busy), 32'd1);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("pending_valid", 32'(rsp_valid), 32'd1);
        chk("pending_data", 32'(rsp_data), 32'h0B);
        @(posedge clk); #1;

        // Reset pulsed mid COUNT run
        send(2'b10, 8'h10, 8'h00, 1'b0, 4'd8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("count_running", 32'({busy, alu_En}), 32'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ctrl", 32'({busy, cmd_ready, rsp_valid, alu_L, alu_En, rsp_cout}), 32'b010000);
        chk("async_reset_data", 32'({alu_s, alu_x, alu_y, rsp_data}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("no_rsp_after_abort", 32'(rsp_valid), 32'd0);
        end
        do_cmd("add_after_reset", 2'b00, 8'h01, 8'h01, 1'b0, 4'd0, 1, 8'h02, 1'b0, 0, 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
- REQ-001: Parameter LEN_W, default 4, width of the cmd_len cycle-count field.
- REQ-002: clock  input  1  single clock; all state updates on its rising edge.
- REQ-003: reset  input  1  asynchronous, active-low reset; when low, the block enters the reset state immediately, independent of clock.
- REQ-004: cmd_valid  input  1  command offered; cmd_ready  output  1  command accepted when both are high on a rising edge.
- REQ-005: cmd_op  input  2  00 ADD, 01 SHIFT, 10 COUNT, 11 LOGIC.
- REQ-006: cmd_a  input  8  first operand / serial input / counter load value; cmd_b  input  8  second operand.
- REQ-007: cmd_cin  input  1  adder carry-in; cmd_len  input  LEN_W  run length for SHIFT/COUNT.
- REQ-008: alu_x, alu_y  output  8 each; alu_L, alu_En  output  1 each; alu_s  output  2  drive the ALU datapath.
- REQ-009: alu_f  input  8  ALU result; alu_cout  input  1  adder carry-out.
- REQ-010: rsp_valid  output  1; rsp_ready  input  1; rsp_data  output  8; rsp_cout  output  1  result handshake.
- REQ-011: busy  output  1  high in every state except IDLE.

Function
- REQ-012: FSM states IDLE, LOAD, RUN, SAMPLE, RESP; all outputs registered, except that cmd_ready = (state==IDLE) and busy = (state!=IDLE).
- REQ-013: IDLE: on cmd_valid&cmd_ready, latch op/a/b/cin/len; alu_s<=op, alu_x<=a, alu_y<=b; go to LOAD if COUNT, else RUN.
- REQ-014: alu_s, alu_x and alu_y hold the latched values unchanged from acceptance until return to IDLE.
- REQ-015: ADD/LOGIC: RUN lasts exactly 1 cycle, with alu_L=cin for ADD and 0 for LOGIC; at the edge ending RUN, capture rsp_data<=alu_f, rsp_cout<=alu_cout for ADD, 0 for LOGIC; go to RESP.
- REQ-016: COUNT: LOAD lasts 1 cycle with alu_L=1, alu_En=1; then RUN lasts N cycles with alu_L=0, alu_En=1; then SAMPLE lasts 1 cycle with alu_En=0; capture alu_f at the edge ending SAMPLE; rsp_cout=0.
- REQ-017: SHIFT: RUN lasts N cycles with alu_L=0, alu_En=0; then SAMPLE lasts 1 cycle; capture alu_f at the edge ending SAMPLE; rsp_cout=0.
- REQ-018: N = cmd_len, except that cmd_len=0 is treated as N=1; cmd_len is ignored for ADD/LOGIC.
- REQ-019: The RUN counter is a LEN_W-bit down-counter loaded with N and exits RUN at count 1; it never wraps.
- REQ-020: alu_L=0 and alu_En=0 in IDLE, SAMPLE and RESP.
- REQ-021: RESP: rsp_valid=1; rsp_data and rsp_cout stay stable until the edge on which rsp_ready=1; at that edge, rsp_valid<=0 and the FSM goes to IDLE.
- REQ-022: rsp_ready already high on entry to RESP gives a 1-cycle rsp_valid pulse.
- REQ-023: No command is accepted outside IDLE (cmd_ready=0); cmd_valid while busy is held off, not dropped.
- REQ-024: The cycle after RESP exits, IDLE accepts a pending command (minimum 1 idle cycle between commands).
- REQ-025: Latency from the acceptance edge to rsp_valid high: ADD/LOGIC 1 edge; SHIFT N+1 edges; COUNT N+2 edges.
- REQ-026: The COUNT result is the 8-bit datapath value; wrap-around mod 256 belongs to the datapath, and the sequencer passes alu_f through unmodified.

Reset
- REQ-027: While reset is low: state=IDLE; alu_x=0, alu_y=0, alu_s=00, alu_L=0, alu_En=0; rsp_valid=0, rsp_data=0, rsp_cout=0; the RUN counter is 0; busy=0; cmd_ready=1.
- REQ-028: Reset asserted mid-command (any state) aborts the command with no response; on release, the block is idle and the next command executes normally.

Verification
- REQ-029: ADD a=0xF0, b=0x20, cin=1, rsp_ready=1 -> rsp_valid 1 edge after acceptance, rsp_data=0x11, rsp_cout=1, alu_s=00 throughout.
- REQ-030: COUNT a=0xFE, len=3 -> alu_L=1 for exactly 1 cycle, alu_En=1 for 4 cycles, rsp_valid after 5 edges, rsp_data=0x01 (wrap), rsp_cout=0.
- REQ-031: SHIFT len=0 -> treated as N=1: alu_s=01 for 2 cycles before RESP, rsp_valid 2 edges after acceptance.
- REQ-032: LOGIC a=0x3C, b=0x0F, rsp_ready held low 5 cycles -> rsp_valid and rsp_data=0x0C stable for all 5 cycles; second cmd_valid during the stall gets cmd_ready=0 and is accepted 1 cycle after the rsp handshake.
- REQ-033: Reset pulsed low during COUNT RUN (len=8) -> all outputs return to reset values asynchronously with no rsp_valid; a following ADD a=1, b=1 returns rsp_data=0x02.
